// File: rtl/iic_bus_arbiter_pkg.sv
// Shared types and defaults for the IIC bus arbiter.
// Latency: n/a (declarations only).  Backpressure: n/a.
package iic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ISSUE,
        WAIT_START,
        WAIT_END,
        DONE,
        GAP
    } state_t;

    localparam logic [7:0] DEF_DEV_ADDR      = 8'hd6;
    localparam int         DEF_STROBE_CYCLES = 10;
    localparam int         DEF_START_TIMEOUT = 1000;
    localparam int         DEF_BUSY_TIMEOUT  = 200000;
    localparam int         DEF_GAP_CYCLES    = 100;

    // One requester's transaction as presented to the IIC master.
    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] reg_addr;
        logic [7:0]  reg_data;
        logic        two_addr;
        logic        rd;
    } txn_t;

endpackage

// File: rtl/iic_bus_arbiter_rr.sv
// Round-robin picker: first set request at or after the pointer, wrapping.
// Latency: grant/idx combinational; pointer moves on the clock after advance.
// Backpressure: none; caller decides when to advance.
module rr_arbiter
    import iic_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk_100MHz,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               req_any
);

    logic [IDX_W-1:0] ptr;
    int               cand;

    always_comb begin
        grant   = '0;
        idx     = '0;
        req_any = 1'b0;
        cand    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!req_any && cand == j && req[j]) begin
                    req_any  = 1'b1;
                    grant[j] = 1'b1;
                    idx      = IDX_W'(j);
                end
            end
        end
    end

    // Pointer moves past the winner so a re-requesting winner cannot starve others.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && req_any) begin
            ptr <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/iic_bus_arbiter.sv
// Shares one IIC master among NUM_REQ drivers, round-robin, one transaction at a time.
// Latency: Req->Done >= 1 + 1 + STROBE_CYCLES + busy cycle + 2 sync + 1.
// Backpressure: Req is a held level; new requests are ignored until GAP has elapsed.
module iic_bus_arbiter
    import iic_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT,
    parameter int BUSY_TIMEOUT  = DEF_BUSY_TIMEOUT,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES
) (
    input  logic                    clk_100MHz,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      Req,
    input  logic [NUM_REQ-1:0]      Req_Rd,
    input  logic [8*NUM_REQ-1:0]    Req_Addr,
    input  logic [16*NUM_REQ-1:0]   Req_Reg_Addr,
    input  logic [8*NUM_REQ-1:0]    Req_Reg_Data,
    input  logic [NUM_REQ-1:0]      Req_2Addr,
    output logic [NUM_REQ-1:0]      Grant,
    output logic [NUM_REQ-1:0]      Done,
    output logic                    Err,
    output logic [7:0]              Rd_Data,
    input  logic                    IIC_Busy,
    input  logic [7:0]              IIC_Data,
    output logic                    IIC_Write,
    output logic                    IIC_Read,
    output logic [7:0]              Addr,
    output logic [15:0]             Reg_Addr,
    output logic [7:0]              Reg_Data,
    output logic                    Reg_2Addr,
    output logic                    Ctrl_IIC
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state, state_nxt;
    logic               busy_m, busy_s, busy_d, busy_rise;
    logic [31:0]        cnt;
    logic               cnt_clr, cnt_run, set_err, cap_rd;
    logic               started, err_q, rd_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    txn_t               sel_txn;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .req        (Req),
        .advance    (state == ARB),
        .grant      (arb_grant),
        .idx        (arb_idx),
        .req_any    (arb_any)
    );

    always_comb begin
        sel_txn = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (arb_idx == IDX_W'(j)) begin
                sel_txn.addr     = Req_Addr[8*j +: 8];
                sel_txn.reg_addr = Req_Reg_Addr[16*j +: 16];
                sel_txn.reg_data = Req_Reg_Data[8*j +: 8];
                sel_txn.two_addr = Req_2Addr[j];
                sel_txn.rd       = Req_Rd[j];
            end
        end
    end

    assign busy_rise = busy_s & ~busy_d;

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        set_err   = 1'b0;
        cap_rd    = 1'b0;
        cnt_run   = 1'b0;
        case (state)
            IDLE: begin
                if (|Req) state_nxt = ARB;
            end
            ARB: begin
                cnt_clr   = 1'b1;
                state_nxt = arb_any ? ISSUE : IDLE;
            end
            ISSUE: begin
                cnt_run = 1'b1;
                if (cnt >= 32'(STROBE_CYCLES - 1)) begin
                    if (started || busy_rise) begin
                        state_nxt = WAIT_END;
                        cnt_clr   = 1'b1;
                    end else begin
                        state_nxt = WAIT_START;
                    end
                end
            end
            WAIT_START: begin
                // cnt keeps running from strobe assert, so the limit covers ISSUE too
                cnt_run = 1'b1;
                if (busy_rise) begin
                    state_nxt = WAIT_END;
                    cnt_clr   = 1'b1;
                end else if (cnt >= 32'(START_TIMEOUT)) begin
                    set_err   = 1'b1;
                    state_nxt = DONE;
                end
            end
            WAIT_END: begin
                cnt_run = 1'b1;
                if (!busy_s) begin
                    cap_rd    = rd_q;
                    state_nxt = DONE;
                end else if (cnt >= 32'(BUSY_TIMEOUT - 1)) begin
                    set_err   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                cnt_clr   = 1'b1;
                state_nxt = GAP;
            end
            GAP: begin
                cnt_run = 1'b1;
                if (cnt >= 32'(GAP_CYCLES - 1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            busy_m    <= 1'b0;
            busy_s    <= 1'b0;
            busy_d    <= 1'b0;
            cnt       <= '0;
            started   <= 1'b0;
            err_q     <= 1'b0;
            rd_q      <= 1'b0;
            grant_q   <= '0;
            Rd_Data   <= '0;
            Addr      <= DEF_DEV_ADDR;
            Reg_Addr  <= '0;
            Reg_Data  <= '0;
            Reg_2Addr <= 1'b0;
        end else begin
            busy_m <= IIC_Busy;
            busy_s <= busy_m;
            busy_d <= busy_s;

            if (cnt_clr)      cnt <= '0;
            else if (cnt_run) cnt <= cnt + 32'd1;

            if (state == ARB && arb_any) begin
                grant_q   <= arb_grant;
                Addr      <= sel_txn.addr;
                Reg_Addr  <= sel_txn.reg_addr;
                Reg_Data  <= sel_txn.reg_data;
                Reg_2Addr <= sel_txn.two_addr;
                rd_q      <= sel_txn.rd;
                started   <= 1'b0;
                err_q     <= 1'b0;
            end
            if (state == ISSUE && busy_rise) started <= 1'b1;
            if (set_err)                     err_q   <= 1'b1;
            if (cap_rd)                      Rd_Data <= IIC_Data;
            if (state == DONE)               grant_q <= '0;
        end
    end

    assign Grant     = grant_q;
    assign Done      = (state == DONE) ? grant_q : '0;
    assign Err       = (state == DONE) && err_q;
    assign IIC_Write = (state == ISSUE) && !rd_q;
    assign IIC_Read  = (state == ISSUE) && rd_q;
    assign Ctrl_IIC  = (state == ISSUE) || (state == WAIT_START) ||
                       (state == WAIT_END) || (state == DONE);

endmodule

// File: tb/tb_iic_bus_arbiter.sv
// Directed bench for iic_bus_arbiter with a behavioural IIC master model.
// Latency: n/a.  Backpressure: n/a.
module tb_iic_bus_arbiter;

    localparam int NUM_REQ  = 2;
    localparam int STROBE   = 10;
    localparam int START_TO = 60;
    localparam int BUSY_TO  = 400;
    localparam int GAP      = 20;
    localparam int BUSY_LEN = 30;

    logic        clk_100MHz;
    logic        rst;
    logic [1:0]  Req, Req_Rd, Req_2Addr;
    logic [15:0] Req_Addr, Req_Reg_Data;
    logic [31:0] Req_Reg_Addr;
    logic [1:0]  Grant, Done;
    logic        Err;
    logic [7:0]  Rd_Data;
    logic        IIC_Busy;
    logic [7:0]  IIC_Data;
    logic        IIC_Write, IIC_Read;
    logic [7:0]  Addr;
    logic [15:0] Reg_Addr;
    logic [7:0]  Reg_Data;
    logic        Reg_2Addr, Ctrl_IIC;

    iic_bus_arbiter #(
        .NUM_REQ(NUM_REQ), .STROBE_CYCLES(STROBE), .START_TIMEOUT(START_TO),
        .BUSY_TIMEOUT(BUSY_TO), .GAP_CYCLES(GAP)
    ) dut (
        .clk_100MHz(clk_100MHz), .rst(rst), .Req(Req), .Req_Rd(Req_Rd),
        .Req_Addr(Req_Addr), .Req_Reg_Addr(Req_Reg_Addr), .Req_Reg_Data(Req_Reg_Data),
        .Req_2Addr(Req_2Addr), .Grant(Grant), .Done(Done), .Err(Err), .Rd_Data(Rd_Data),
        .IIC_Busy(IIC_Busy), .IIC_Data(IIC_Data), .IIC_Write(IIC_Write), .IIC_Read(IIC_Read),
        .Addr(Addr), .Reg_Addr(Reg_Addr), .Reg_Data(Reg_Data), .Reg_2Addr(Reg_2Addr),
        .Ctrl_IIC(Ctrl_IIC)
    );

    initial begin
        clk_100MHz = 1'b0;
        forever #5 clk_100MHz = ~clk_100MHz;
    end

    // master model modes: 0 = normal busy pulse, 1 = never busy, 2 = busy stuck high
    int         mdl_mode;
    logic [7:0] mdl_rdata;

    initial begin
        int n;
        IIC_Busy = 1'b0;
        IIC_Data = 8'h00;
        forever begin
            @(posedge clk_100MHz); #1;
            if (IIC_Write || IIC_Read) begin
                if (mdl_mode != 1) begin
                    repeat (5) @(posedge clk_100MHz);
                    #1;
                    IIC_Data = mdl_rdata;
                    IIC_Busy = 1'b1;
                    if (mdl_mode == 0) begin
                        repeat (BUSY_LEN) @(posedge clk_100MHz);
                        #1;
                    end else begin
                        n = 0;
                        while (Done == 2'b00 && !rst && n < 5000) begin
                            @(posedge clk_100MHz); #1;
                            n++;
                        end
                    end
                    IIC_Busy = 1'b0;
                end
                n = 0;
                while ((IIC_Write || IIC_Read) && n < 100) begin
                    @(posedge clk_100MHz); #1;
                    n++;
                end
            end
        end
    end

    int         cyc = 0, wr_total = 0, rd_total = 0, done_total = 0, grant_total = 0;
    int         done_cyc = -1000, grant_cyc = 0, gap_last = 0;
    logic [1:0] done_vec = 2'b00, grant_last = 2'b00, grant_prev = 2'b00;
    logic       err_last = 1'b0;
    logic [7:0] rdd_last = 8'h00;

    always @(negedge clk_100MHz) begin
        cyc++;
        if (IIC_Write) wr_total++;
        if (IIC_Read)  rd_total++;
        if (Grant != 2'b00 && grant_prev == 2'b00) begin
            grant_total++;
            grant_cyc  = cyc;
            grant_last = Grant;
            gap_last   = cyc - done_cyc - 1;
        end
        grant_prev = Grant;
        if (Done != 2'b00) begin
            done_total++;
            done_vec = Done;
            err_last = Err;
            rdd_last = Rd_Data;
            done_cyc = cyc;
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_100MHz); #1;
    endtask

    task automatic wait_done(input int d0, input string nm);
        int n = 0;
        while (done_total == d0 && n < 3000) begin
            tick();
            n++;
        end
        chk({nm, "_done_seen"}, 32'(done_total != d0), 32'd1);
    endtask

    task automatic wait_grant(input int g0, input string nm);
        int n = 0;
        while (grant_total == g0 && n < 300) begin
            tick();
            n++;
        end
        chk({nm, "_grant_seen"}, 32'(grant_total != g0), 32'd1);
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_grant"},  Grant,     0);
        chk({nm, "_done"},   Done,      0);
        chk({nm, "_err"},    Err,       0);
        chk({nm, "_wr"},     IIC_Write, 0);
        chk({nm, "_rd"},     IIC_Read,  0);
        chk({nm, "_ctrl"},   Ctrl_IIC,  0);
        chk({nm, "_2addr"},  Reg_2Addr, 0);
        chk({nm, "_rddata"}, Rd_Data,   0);
        chk({nm, "_addr"},   Addr,      32'hd6);
        chk({nm, "_regadr"}, Reg_Addr,  0);
        chk({nm, "_regdat"}, Reg_Data,  0);
    endtask

    typedef struct {
        logic [1:0]  req;
        logic        rd;
        logic [7:0]  addr;
        logic [15:0] reg_addr;
        logic [7:0]  data;
        logic        two;
        int          mode;
        logic [7:0]  ret;
        logic [1:0]  exp_done;
        logic        exp_err;
        logic [7:0]  exp_rd;
        int          exp_lat;
        int          exp_wr;
        int          exp_rds;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int r, d0, g0, w0, r0;
        string nm;
        rst = 1'b1; Req = '0; Req_Rd = '0; Req_2Addr = '0;
        Req_Addr = '0; Req_Reg_Addr = '0; Req_Reg_Data = '0;
        mdl_mode = 0; mdl_rdata = 8'h00;

        // Latency: normal = 38 (strobe seen, +5 busy, 30 busy, 2 sync, 1 decide);
        // start timeout = START_TO+1 from first Grant cycle; stuck = STROBE+BUSY_TO.
        vecs[0] = '{req:2'b01, rd:1'b0, addr:8'hd6, reg_addr:16'h0010, data:8'h50, two:1'b0, mode:0,
                    ret:8'h00, exp_done:2'b01, exp_err:1'b0, exp_rd:8'h00, exp_lat:38, exp_wr:STROBE, exp_rds:0};
        vecs[1] = '{req:2'b10, rd:1'b1, addr:8'h3c, reg_addr:16'h0022, data:8'h00, two:1'b0, mode:0,
                    ret:8'ha5, exp_done:2'b10, exp_err:1'b0, exp_rd:8'ha5, exp_lat:38, exp_wr:0, exp_rds:STROBE};
        vecs[2] = '{req:2'b01, rd:1'b0, addr:8'hd6, reg_addr:16'h1234, data:8'h77, two:1'b1, mode:1,
                    ret:8'h00, exp_done:2'b01, exp_err:1'b1, exp_rd:8'ha5, exp_lat:START_TO+1, exp_wr:STROBE, exp_rds:0};
        vecs[3] = '{req:2'b10, rd:1'b1, addr:8'h1e, reg_addr:16'h0005, data:8'h00, two:1'b0, mode:2,
                    ret:8'hee, exp_done:2'b10, exp_err:1'b1, exp_rd:8'ha5, exp_lat:STROBE+BUSY_TO, exp_wr:0, exp_rds:STROBE};
        vecs[4] = '{req:2'b10, rd:1'b1, addr:8'h1e, reg_addr:16'h000e, data:8'h00, two:1'b0, mode:0,
                    ret:8'h3c, exp_done:2'b10, exp_err:1'b0, exp_rd:8'h3c, exp_lat:38, exp_wr:0, exp_rds:STROBE};

        repeat (3) tick();
        check_reset("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            nm = $sformatf("v%0d", i);
            r = (vecs[i].req == 2'b01) ? 0 : 1;
            Req_Rd[r]               = vecs[i].rd;
            Req_Addr[8*r +: 8]      = vecs[i].addr;
            Req_Reg_Addr[16*r +: 16] = vecs[i].reg_addr;
            Req_Reg_Data[8*r +: 8]  = vecs[i].data;
            Req_2Addr[r]            = vecs[i].two;
            mdl_mode  = vecs[i].mode;
            mdl_rdata = vecs[i].ret;
            d0 = done_total; w0 = wr_total; r0 = rd_total;
            Req = vecs[i].req;
            wait_done(d0, nm);
            Req = '0;
            chk({nm, "_donevec"}, done_vec, vecs[i].exp_done);
            chk({nm, "_err"},     err_last, vecs[i].exp_err);
            chk({nm, "_rddata"},  rdd_last, vecs[i].exp_rd);
            chk({nm, "_latency"}, done_cyc - grant_cyc, vecs[i].exp_lat);
            chk({nm, "_wr_cyc"},  wr_total - w0, vecs[i].exp_wr);
            chk({nm, "_rd_cyc"},  rd_total - r0, vecs[i].exp_rds);
            chk({nm, "_addr"},    Addr, vecs[i].addr);
            chk({nm, "_regadr"},  Reg_Addr, vecs[i].reg_addr);
            chk({nm, "_regdat"},  Reg_Data, vecs[i].data);
            chk({nm, "_2addr"},   Reg_2Addr, vecs[i].two);
            repeat (GAP + 5) tick();
        end

        // Contention: both held, pointer sits at 0 after requester 1 was last served.
        Req_Rd = 2'b00; Req_2Addr = 2'b00;
        mdl_mode = 0; mdl_rdata = 8'h11;
        d0 = done_total;
        Req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_done(d0 + k, $sformatf("cont%0d", k));
            chk($sformatf("cont%0d_winner", k), done_vec, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("cont%0d_err", k), err_last, 0);
            if (k < 3) begin
                g0 = grant_total;
                wait_grant(g0, $sformatf("cont%0d", k));
                chk($sformatf("cont%0d_gap_ok", k), 32'(gap_last >= GAP), 32'd1);
            end
        end
        Req = '0;
        repeat (GAP + 5) tick();

        // Reset in the middle of a stuck WAIT_END, then requester 1 pending.
        mdl_mode = 2; mdl_rdata = 8'h99;
        Req_Rd[0] = 1'b0;
        g0 = grant_total;
        Req = 2'b01;
        wait_grant(g0, "rt");
        repeat (40) tick();
        chk("rt_ctrl_before", Ctrl_IIC, 1);
        chk("rt_grant_before", Grant, 2'b01);
        Req = 2'b10;
        Req_Rd[1] = 1'b1;
        rst = 1'b1;
        #2;
        check_reset("midrst");
        repeat (3) tick();
        mdl_mode = 0; mdl_rdata = 8'h5a;
        g0 = grant_total; d0 = done_total;
        rst = 1'b0;
        wait_grant(g0, "post");
        chk("post_first_grant", grant_last, 2'b10);
        wait_done(d0, "post");
        Req = '0;
        chk("post_donevec", done_vec, 2'b10);
        chk("post_err", err_last, 0);
        chk("post_rddata", rdd_last, 8'h5a);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
